// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter unit and its
// return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: when full, a push overwrites the oldest
// entry, so the newest DEPTH return addresses are always retained.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_RAS_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              ovf_evt,
  output logic              udf_evt
);

  logic [ADDR_W-1:0] mem_reg [DEPTH];
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [CW-1:0]     count_reg, count_next;

  // ptr_reg names the next free slot; the top of stack sits just below it.
  assign top     = mem_reg[ptr_reg - PW'(1)];
  assign count   = count_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign ovf_evt = push & full;
  assign udf_evt = pop & empty;

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    if (push) begin
      ptr_next = ptr_reg + PW'(1);
      if (!full) count_next = count_reg + CW'(1);
    end else if (pop && !empty) begin
      ptr_next   = ptr_reg - PW'(1);
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  // Entry contents are don't-care after reset; count_reg gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_reg[ptr_reg] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC select (ret > call > jump
// > branch > sequential), stall hold, return-address stack and sticky errors.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter int              STEP      = 1,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int             CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] pc,
  output logic [CW-1:0]     ras_count,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_udf
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_reg, pc_next, pc_seq, ras_top;
  logic              ovf_reg, udf_reg;
  logic              ras_push, ras_pop, ovf_evt, udf_evt;

  assign pc_seq = pc_reg + ADDR_W'(STEP);

  always_comb begin
    sel = SEL_SEQ;
    if (ret)               sel = SEL_RET;
    else if (call)         sel = SEL_CALL;
    else if (jump)         sel = SEL_JMP;
    else if (branch_taken) sel = SEL_BR;
  end

  // Only the winning request may touch the stack; a stall blocks both.
  assign ras_push = !stall && (sel == SEL_CALL);
  assign ras_pop  = !stall && (sel == SEL_RET);

  always_comb begin
    pc_next = pc_reg;
    if (!stall) begin
      unique case (sel)
        SEL_RET:  pc_next = ras_empty ? pc_seq : ras_top;
        SEL_CALL: pc_next = jump_target;
        SEL_JMP:  pc_next = jump_target;
        SEL_BR:   pc_next = branch_target;
        default:  pc_next = pc_seq;
      endcase
    end
  end

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf_evt   (ovf_evt),
    .udf_evt   (udf_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= RESET_PC;
    else     pc_reg <= pc_next;
  end

  // A fresh error event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (ovf_evt)      ovf_reg <= 1'b1;
      else if (clr_err) ovf_reg <= 1'b0;
      if (udf_evt)      udf_reg <= 1'b1;
      else if (clr_err) udf_reg <= 1'b0;
    end
  end

  assign pc      = pc_reg;
  assign ras_ovf = ovf_reg;
  assign ras_udf = udf_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit at ADDR_W=12, STEP=1, RAS_DEPTH=4, RESET_PC=0.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = '0;
  logic        jump = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [11:0] jump_target = '0;
  logic        clr_err = 1'b0;
  logic [11:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_udf;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .ADDR_W    (12),
    .STEP      (1),
    .RAS_DEPTH (4),
    .RESET_PC  (12'h000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .clr_err       (clr_err),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_ovf       (ras_ovf),
    .ras_udf       (ras_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; clr_err = 0;
  endtask

  task automatic do_jump(input logic [11:0] t);
    idle(); jump = 1; jump_target = t;
    step(); idle();
  endtask

  task automatic do_call(input logic [11:0] t);
    idle(); call = 1; jump_target = t;
    step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1;
    step(); idle();
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle, then sequential counting
    #7 rst = 1;
    #1;
    check("rst_pc", pc, 12'h000);
    check("rst_count", ras_count, 3'd0);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_flags", {ras_ovf, ras_udf}, 2'b00);
    #5 rst = 0;
    step(); check("seq1", pc, 12'h001);
    step(); check("seq2", pc, 12'h002);
    step(); check("seq3", pc, 12'h003);
    check("seq_empty", ras_empty, 1'b1);

    // 2: branch near the top of the address space, then silent wrap
    branch_taken = 1; branch_target = 12'hFFE;
    step(); idle(); check("br_pc", pc, 12'hFFE);
    step(); check("wrap_fff", pc, 12'hFFF);
    step(); check("wrap_000", pc, 12'h000);
    check("wrap_flags", {ras_ovf, ras_udf}, 2'b00);

    // 3: stall holds PC and RAS even with a call requested
    do_jump(12'h005); check("jmp_005", pc, 12'h005);
    stall = 1; call = 1; jump_target = 12'h300;
    step(); check("stall1_pc", pc, 12'h005); check("stall1_cnt", ras_count, 3'd0);
    step(); check("stall2_pc", pc, 12'h005); check("stall2_cnt", ras_count, 3'd0);
    idle();
    step(); check("unstall_pc", pc, 12'h006);

    // 4: call / return, and ret outranking a same-cycle branch
    do_jump(12'h010);
    do_call(12'h100); check("call_pc", pc, 12'h100); check("call_cnt", ras_count, 3'd1);
    step(); step(); check("idle_102", pc, 12'h102);
    do_ret(); check("ret_pc", pc, 12'h011); check("ret_cnt", ras_count, 3'd0);
    do_jump(12'h04F);
    do_call(12'h070); check("call2_pc", pc, 12'h070);
    ret = 1; branch_taken = 1; branch_target = 12'h200;
    step(); idle();
    check("ret_over_br", pc, 12'h050);
    check("ret_over_br_cnt", ras_count, 3'd0);
    jump = 1; jump_target = 12'h123; branch_taken = 1; branch_target = 12'h200;
    step(); idle();
    check("jmp_over_br", pc, 12'h123);

    // 5: overflow by five calls, then unwind and underflow
    do_jump(12'h020);
    do_call(12'h040);
    do_call(12'h060);
    do_call(12'h080);
    do_call(12'h0A0);
    check("full4", ras_full, 1'b1); check("ovf_not_yet", ras_ovf, 1'b0);
    do_call(12'h0C0);
    check("ovf_set", ras_ovf, 1'b1); check("ovf_cnt", ras_count, 3'd4);
    check("ovf_pc", pc, 12'h0C0);
    do_ret(); check("pop1", pc, 12'h0A1); check("pop1_cnt", ras_count, 3'd3);
    do_ret(); check("pop2", pc, 12'h081);
    do_ret(); check("pop3", pc, 12'h061);
    do_ret(); check("pop4", pc, 12'h041); check("pop4_empty", ras_empty, 1'b1);
    do_ret(); check("udf_pc", pc, 12'h042); check("udf_set", ras_udf, 1'b1);
    check("udf_cnt", ras_count, 3'd0); check("ovf_sticky", ras_ovf, 1'b1);

    // 6: clearing flags, set-wins, and reset mid-run with a populated stack
    clr_err = 1; step(); idle();
    check("clr_flags", {ras_ovf, ras_udf}, 2'b00);
    check("clr_pc", pc, 12'h043);
    ret = 1; clr_err = 1; step(); idle();
    check("set_wins_udf", ras_udf, 1'b1); check("set_wins_pc", pc, 12'h044);
    clr_err = 1; step(); idle();
    check("clr2_udf", ras_udf, 1'b0);
    do_call(12'h300);
    do_call(12'h310);
    do_call(12'h320);
    check("pre_rst_cnt", ras_count, 3'd3);
    #3 rst = 1;
    #1;
    check("rst2_pc", pc, 12'h000);
    check("rst2_cnt", ras_count, 3'd0);
    #2 rst = 0;
    step(); check("post_rst_pc", pc, 12'h001); check("post_rst_empty", ras_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
